// File: rtl/instr_receiver_pkg.sv
// Shared definitions for the instruction receiver: FSM encoding and default sizes.
package instr_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_IWIDTH = 32;
    localparam int DEF_FDEPTH = 8;
    localparam int DEF_AWIDTH = 3;

endpackage

// File: rtl/instr_receiver_if.sv
// Word bus of the receiver: upstream syn/ack source side and downstream FWFT consumer side.
interface instr_receiver_if #(
    parameter int IWIDTH = instr_receiver_pkg::DEF_IWIDTH
) ();

    logic              t_o_syn;
    logic [IWIDTH-1:0] t_i_instr;
    logic              t_i_ack;
    logic              t_i_last;
    logic [IWIDTH-1:0] t_o_instr;
    logic              t_o_valid;
    logic              t_i_ready;

    modport slave (
        output t_o_syn, t_o_instr, t_o_valid,
        input  t_i_instr, t_i_ack, t_i_last, t_i_ready
    );

    modport master (
        input  t_o_syn, t_o_instr, t_o_valid,
        output t_i_instr, t_i_ack, t_i_last, t_i_ready
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO only lands when a pop frees a slot.
module instr_fifo #(
    parameter int IWIDTH = 32,
    parameter int FDEPTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              t_clk,
    input  logic              t_rst,
    input  logic              push,
    input  logic [IWIDTH-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [AWIDTH:0]   count,
    output logic [IWIDTH-1:0] head
);

    logic [IWIDTH-1:0] mem [FDEPTH];
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AWIDTH+1)'(FDEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rptr];

    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AWIDTH'(1);
            if (pop_ok)  rptr <= rptr + AWIDTH'(1);
            count <= count + (AWIDTH+1)'(push_ok) - (AWIDTH+1)'(pop_ok);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge t_clk) begin
        if (push_ok) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/instr_receiver.sv
// Program loader: requests words from a syn/ack source with credit flow control and buffers them for a consumer.
module instr_receiver
    import instr_receiver_pkg::*;
#(
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int FDEPTH = DEF_FDEPTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic                t_clk,
    input  logic                t_rst,
    input  logic                t_i_start,
    instr_receiver_if.slave     bus,
    output logic                t_o_busy,
    output logic                t_o_done,
    output logic                t_o_err
);

    state_t            state;
    state_t            state_nxt;
    logic              syn;
    logic              syn_nxt;
    logic              fetch_push;
    logic              pop_ok;
    logic              push_ok;
    logic              overflow;
    logic              full;
    logic              empty;
    logic [AWIDTH:0]   count;
    logic [AWIDTH:0]   count_nxt;
    logic [AWIDTH+1:0] need;
    logic [IWIDTH-1:0] head;

    instr_fifo #(
        .IWIDTH (IWIDTH),
        .FDEPTH (FDEPTH),
        .AWIDTH (AWIDTH)
    ) u_fifo (
        .t_clk     (t_clk),
        .t_rst     (t_rst),
        .push      (fetch_push),
        .push_data (bus.t_i_instr),
        .pop       (bus.t_i_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    assign fetch_push = bus.t_i_ack && (state == ST_FETCH);
    assign pop_ok     = !empty && bus.t_i_ready;
    assign push_ok    = fetch_push && (!full || pop_ok);
    assign overflow   = fetch_push && full && !pop_ok;
    assign count_nxt  = count + (AWIDTH+1)'(push_ok) - (AWIDTH+1)'(pop_ok);

    // Credit: buffered words, the ack still in flight and the new request must all fit.
    assign need    = (AWIDTH+2)'(count_nxt) + (AWIDTH+2)'(syn) + (AWIDTH+2)'(1);
    assign syn_nxt = (state_nxt == ST_FETCH) && (need <= (AWIDTH+2)'(FDEPTH));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (t_i_start) state_nxt = ST_FETCH;
            ST_FETCH: if (fetch_push && bus.t_i_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (empty && !syn) state_nxt = ST_DONE;
            ST_DONE:  if (t_i_start) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            state    <= ST_IDLE;
            syn      <= 1'b0;
            t_o_busy <= 1'b0;
            t_o_done <= 1'b0;
            t_o_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            syn      <= syn_nxt;
            t_o_busy <= (state_nxt == ST_FETCH) || (state_nxt == ST_DRAIN);
            t_o_done <= (state_nxt == ST_DONE);
            if (overflow) t_o_err <= 1'b1;
        end
    end

    assign bus.t_o_syn   = syn;
    assign bus.t_o_valid = !empty;
    assign bus.t_o_instr = head;

endmodule

// File: tb/tb_instr_receiver.sv
// Directed bench for instr_receiver: a syn/ack source model, a consumer collector and hand-built expected sequences.
module tb_instr_receiver;

    logic t_clk = 1'b0;
    logic t_rst;
    logic t_i_start;
    logic t_o_busy;
    logic t_o_done;
    logic t_o_err;

    instr_receiver_if #(.IWIDTH(32)) bus ();

    instr_receiver #(
        .IWIDTH (32),
        .FDEPTH (8),
        .AWIDTH (3)
    ) dut (
        .t_clk     (t_clk),
        .t_rst     (t_rst),
        .t_i_start (t_i_start),
        .bus       (bus),
        .t_o_busy  (t_o_busy),
        .t_o_done  (t_o_done),
        .t_o_err   (t_o_err)
    );

    always #5 t_clk = ~t_clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog [0:31];
    int          plen;
    int          sidx;
    int          acks;
    logic        pend;
    logic        inj;
    logic [31:0] inj_word;
    logic        rdy;
    logic        start_req;
    logic [31:0] rcv [$];
    logic [31:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: drive this cycle's inputs at the falling edge, answer last cycle's syn, collect pops.
    task automatic step();
        @(negedge t_clk);
        t_i_start     = start_req;
        start_req     = 1'b0;
        bus.t_i_ready = rdy;
        if (inj) begin
            bus.t_i_ack   = 1'b1;
            bus.t_i_instr = inj_word;
            bus.t_i_last  = 1'b0;
            inj           = 1'b0;
        end else if (pend) begin
            bus.t_i_ack = 1'b1;
            if (sidx < plen) begin
                bus.t_i_instr = prog[sidx];
                bus.t_i_last  = (sidx == plen - 1);
                sidx++;
                acks++;
            end else begin
                bus.t_i_instr = 32'h0000_00EE;
                bus.t_i_last  = 1'b0;
            end
        end else begin
            bus.t_i_ack   = 1'b0;
            bus.t_i_last  = 1'b0;
            bus.t_i_instr = '0;
        end
        pend = bus.t_o_syn;
        if (bus.t_o_valid && rdy) rcv.push_back(bus.t_o_instr);
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) prog[i] = base + 32'(i);
        plen = n;
        sidx = 0;
        acks = 0;
        pend = 1'b0;
        rcv.delete();
        expq.delete();
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!t_o_done && k < bound) begin
            step();
            k++;
        end
        chk(tag, 32'(t_o_done), 32'd1);
    endtask

    task automatic cmp_rcv(input string tag);
        chk({tag, "_len"}, 32'(rcv.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (i < rcv.size()) chk(tag, rcv[i], expq[i]);
            else                chk(tag, 32'hxxxx_xxxx, expq[i]);
        end
    endtask

    initial begin
        t_rst         = 1'b0;
        t_i_start     = 1'b0;
        start_req     = 1'b0;
        rdy           = 1'b0;
        inj           = 1'b0;
        inj_word      = '0;
        pend          = 1'b0;
        plen          = 0;
        sidx          = 0;
        acks          = 0;
        bus.t_i_ack   = 1'b0;
        bus.t_i_last  = 1'b0;
        bus.t_i_instr = '0;
        bus.t_i_ready = 1'b0;
        repeat (2) step();
        chk("rst_syn",   32'(bus.t_o_syn),   32'd0);
        chk("rst_valid", 32'(bus.t_o_valid), 32'd0);
        chk("rst_busy",  32'(t_o_busy),      32'd0);
        chk("rst_done",  32'(t_o_done),      32'd0);
        chk("rst_err",   32'(t_o_err),       32'd0);
        t_rst = 1'b1;
        step();

        // Basic load with request latency and trailing-ack discard.
        load(32'h0, 0);
        prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = 32'h44;
        plen = 4;
        rdy = 1'b1;
        start_req = 1'b1;
        step();
        chk("lat_syn_n",    32'(bus.t_o_syn),   32'd0);
        step();
        chk("lat_syn_n1",   32'(bus.t_o_syn),   32'd1);
        chk("lat_busy_n1",  32'(t_o_busy),      32'd1);
        step();
        chk("lat_valid_n2", 32'(bus.t_o_valid), 32'd0);
        step();
        chk("lat_valid_n3", 32'(bus.t_o_valid), 32'd1);
        chk("lat_head_n3",  bus.t_o_instr,      32'h11);
        wait_done("basic_done", 40);
        expq = '{32'h11, 32'h22, 32'h33, 32'h44};
        cmp_rcv("basic_word");
        chk("basic_err",  32'(t_o_err),  32'd0);
        chk("basic_busy", 32'(t_o_busy), 32'd0);

        // Back-pressure: twenty words, consumer stalled, restart from DONE.
        load(32'h100, 20);
        rdy = 1'b0;
        start_req = 1'b1;
        repeat (30) step();
        chk("bp_syn_low",  32'(bus.t_o_syn),   32'd0);
        chk("bp_held",     32'(acks),          32'd8);
        chk("bp_head",     bus.t_o_instr,      32'h100);
        repeat (5) step();
        chk("bp_held_still", 32'(acks),        32'd8);
        chk("bp_err",      32'(t_o_err),       32'd0);
        rdy = 1'b1;
        wait_done("bp_done", 200);
        for (int i = 0; i < 20; i++) expq.push_back(32'h100 + 32'(i));
        cmp_rcv("bp_word");
        chk("bp_err_end",  32'(t_o_err),       32'd0);

        // Push and pop together while full, then a push while full with no pop.
        load(32'h300, 20);
        rdy = 1'b0;
        start_req = 1'b1;
        repeat (30) step();
        chk("full_held",   32'(acks),          32'd8);
        inj_word = 32'hAAAA_0001;
        inj = 1'b1;
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
        chk("pp_full_syn", 32'(bus.t_o_syn),   32'd0);
        chk("pp_full_err", 32'(t_o_err),       32'd0);
        chk("pp_full_head", bus.t_o_instr,     32'h301);
        inj_word = 32'hBBBB_0002;
        inj = 1'b1;
        step();
        step();
        chk("ovf_err",     32'(t_o_err),       32'd1);
        chk("ovf_head",    bus.t_o_instr,      32'h301);
        rdy = 1'b1;
        wait_done("ovf_done", 200);
        for (int i = 0; i < 8; i++) expq.push_back(32'h300 + 32'(i));
        expq.push_back(32'hAAAA_0001);
        for (int i = 8; i < 20; i++) expq.push_back(32'h300 + 32'(i));
        cmp_rcv("ovf_word");
        chk("ovf_err_held", 32'(t_o_err),      32'd1);
        #2 t_rst = 1'b0;
        #1;
        chk("ovf_err_rst", 32'(t_o_err),       32'd0);
        step();
        t_rst = 1'b1;

        // Reset in the middle of a load, stray ack in IDLE, then reload.
        load(32'h200, 6);
        rdy = 1'b0;
        start_req = 1'b1;
        begin
            int k = 0;
            while (acks < 3 && k < 50) begin
                step();
                k++;
            end
        end
        chk("mid_acks",    32'(acks),          32'd3);
        chk("mid_valid",   32'(bus.t_o_valid), 32'd1);
        #2 t_rst = 1'b0;
        #1;
        chk("mrst_syn",    32'(bus.t_o_syn),   32'd0);
        chk("mrst_valid",  32'(bus.t_o_valid), 32'd0);
        chk("mrst_busy",   32'(t_o_busy),      32'd0);
        chk("mrst_done",   32'(t_o_done),      32'd0);
        chk("mrst_err",    32'(t_o_err),       32'd0);
        pend = 1'b0;
        repeat (2) step();
        t_rst = 1'b1;
        inj_word = 32'hCCCC_0003;
        inj = 1'b1;
        rdy = 1'b1;
        repeat (3) step();
        chk("idle_ack_valid", 32'(bus.t_o_valid), 32'd0);
        chk("idle_busy",   32'(t_o_busy),      32'd0);
        chk("idle_rcv",    32'(rcv.size()),    32'd0);
        load(32'h200, 6);
        start_req = 1'b1;
        wait_done("reload_done", 60);
        for (int i = 0; i < 6; i++) expq.push_back(32'h200 + 32'(i));
        cmp_rcv("reload_word");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
